// File: rtl/apu_result_queue.sv
// apu_result_queue: registered FIFO returning vector-unit results to the core over APU (optional same-cycle bypass via APU_RESULT_BYPASS_EN)
module apu_result_queue #(
  parameter int VLEN  = 128,
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        res_valid_i,
  input  logic [1:0]                  res_src_i,
  input  logic [$clog2(VLEN/8):0]     vl_i,
  input  logic [1:0]                  vsew_i,
  input  logic [$clog2(VLEN/8)-1:0]   elem_idx_i,
  input  logic                        sext_i,
  input  logic [VLEN-1:0]             vs2_data_i,
  output logic                        res_full_o,
  output logic                        apu_rvalid,
  input  logic                        apu_rready_i,
  output logic [XLEN-1:0]             apu_result,
  output logic [4:0]                  apu_flags_o,
  output logic                        err_overflow_o
);
  localparam int IW = $clog2(VLEN/8);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [IW-1:0] N16 = IW'(VLEN/16);
  localparam logic [IW-1:0] N32 = IW'(VLEN/32);
  logic [XLEN+4:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [IW+4:0] sh_amt;
  logic [31:0] elem;
  logic [XLEN-1:0] ext8, ext16, ext32, f_res;
  logic [4:0] f_flg;
  logic oob, has, push, pop, wr_en;
  logic [XLEN+4:0] head;
  // Element shift is idx*SEW; an illegal vsew only garbles elem, which is then masked by the flag path
  assign sh_amt = {5'd0, elem_idx_i} << (3'(vsew_i) + 3'd3);
  assign elem = 32'(vs2_data_i >> sh_amt);
  assign ext8  = sext_i ? XLEN'($signed(elem[7:0]))  : XLEN'(elem[7:0]);
  assign ext16 = sext_i ? XLEN'($signed(elem[15:0])) : XLEN'(elem[15:0]);
  assign ext32 = sext_i ? XLEN'($signed(elem))       : XLEN'(elem);
  assign oob = (vsew_i == 2'd1 && elem_idx_i >= N16) || (vsew_i == 2'd2 && elem_idx_i >= N32);
  always_comb begin
    f_res = '0;
    f_flg = '0;
    if (res_src_i == 2'd0) f_res = XLEN'(vl_i);
    else if (res_src_i == 2'd1) begin
      if (vsew_i == 2'd3) f_flg = 5'b00001;
      else if (oob) f_flg = 5'b00010;
      else f_res = vsew_i == 2'd0 ? ext8 : vsew_i == 2'd1 ? ext16 : ext32;
    end
  end
  assign res_full_o = count == CW'(DEPTH);
  assign has = count != '0;
  assign head = mem[rd_ptr];
  assign push = res_valid_i & ~res_full_o;
  assign pop = has & apu_rready_i;
`ifdef APU_RESULT_BYPASS_EN
  // An empty queue forwards the formed result; it is only stored if the core does not take it now
  assign wr_en = push & ~(~has & apu_rready_i);
  assign apu_rvalid = has | res_valid_i;
  assign apu_result = has ? head[XLEN-1:0] : res_valid_i ? f_res : '0;
  assign apu_flags_o = has ? head[XLEN+4:XLEN] : res_valid_i ? f_flg : '0;
`else
  assign wr_en = push;
  assign apu_rvalid = has;
  assign apu_result = has ? head[XLEN-1:0] : '0;
  assign apu_flags_o = has ? head[XLEN+4:XLEN] : '0;
`endif
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr] <= {f_flg, f_res};
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      err_overflow_o <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(wr_en) - CW'(pop);
      if (res_valid_i & res_full_o) err_overflow_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_apu_result_queue.sv
// tb_apu_result_queue: randomized and directed checks of apu_result_queue against a queue-based reference model
module tb_apu_result_queue;
  localparam int VLEN = 128, XLEN = 32, DEPTH = 4;
  localparam int IW = $clog2(VLEN/8);
  logic clk = 0, reset = 0, res_valid_i = 0, sext_i = 0, apu_rready_i = 0;
  logic [1:0] res_src_i = 0, vsew_i = 0;
  logic [IW:0] vl_i = 0;
  logic [IW-1:0] elem_idx_i = 0;
  logic [VLEN-1:0] vs2_data_i = 0;
  logic res_full_o, apu_rvalid, err_overflow_o;
  logic [XLEN-1:0] apu_result;
  logic [4:0] apu_flags_o;
  logic [36:0] q[$];
  logic m_err = 0;
  int n_chk = 0, n_pass = 0;

  apu_result_queue #(.VLEN(VLEN), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .res_valid_i(res_valid_i), .res_src_i(res_src_i),
    .vl_i(vl_i), .vsew_i(vsew_i), .elem_idx_i(elem_idx_i), .sext_i(sext_i),
    .vs2_data_i(vs2_data_i), .res_full_o(res_full_o), .apu_rvalid(apu_rvalid),
    .apu_rready_i(apu_rready_i), .apu_result(apu_result), .apu_flags_o(apu_flags_o),
    .err_overflow_o(err_overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [36:0] form();
    int sew;
    logic [VLEN-1:0] sh;
    logic [63:0] e, m;
    if (res_src_i == 0) return {5'd0, 32'(vl_i)};
    if (res_src_i != 1) return '0;
    if (vsew_i == 3) return {5'b00001, 32'd0};
    sew = 8 << vsew_i;
    if (int'(elem_idx_i) >= VLEN / sew) return {5'b00010, 32'd0};
    sh = vs2_data_i >> (int'(elem_idx_i) * sew);
    m = (64'd1 << sew) - 1;
    e = {32'd0, sh[31:0]} & m;
    if (sext_i && e[sew-1]) e = e | ~m;
    return {5'd0, e[31:0]};
  endfunction

  task automatic check_outputs();
    logic [36:0] exp;
    logic ev;
    ev = q.size() != 0;
    exp = ev ? q[0] : '0;
`ifdef APU_RESULT_BYPASS_EN
    if (!ev && res_valid_i) begin
      ev = 1;
      exp = form();
    end
`endif
    check("rvalid", 64'(apu_rvalid), 64'(ev));
    check("result", 64'(apu_result), 64'(exp[31:0]));
    check("flags", 64'(apu_flags_o), 64'(exp[36:32]));
    check("full", 64'(res_full_o), 64'(q.size() == DEPTH));
    check("overflow", 64'(err_overflow_o), 64'(m_err));
  endtask

  task automatic tick();
    logic [36:0] f;
    logic full, pop, push;
    f = form();
    full = q.size() == DEPTH;
    pop = q.size() != 0 && apu_rready_i;
    push = res_valid_i && !full;
`ifdef APU_RESULT_BYPASS_EN
    if (q.size() == 0 && res_valid_i && apu_rready_i) push = 0;
`endif
    if (res_valid_i && full) m_err = 1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(f);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    res_valid_i = 0;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    q.delete();
    m_err = 0;
    check("rst_rvalid", 64'(apu_rvalid), 0);
    check("rst_result", 64'(apu_result), 0);
    check("rst_flags", 64'(apu_flags_o), 0);
    check("rst_full", 64'(res_full_o), 0);
    check("rst_overflow", 64'(err_overflow_o), 0);
  endtask

  task automatic push_one(input logic [1:0] src, input logic [IW:0] vl, input logic [1:0] sew,
                          input logic [IW-1:0] idx, input logic sx);
    res_valid_i = 1;
    res_src_i = src;
    vl_i = vl;
    vsew_i = sew;
    elem_idx_i = idx;
    sext_i = sx;
    tick();
    res_valid_i = 0;
  endtask

  initial begin
    logic [VLEN-1:0] d;
    do_reset();
    apu_rready_i = 1;
    d = '0;
    d[31:24] = 8'hF0;
    vs2_data_i = d;
    push_one(1, 0, 0, 3, 1);
    check("sext8", 64'(apu_result), 64'h0000_0000_FFFF_FFF0);
    tick();
    push_one(1, 0, 0, 3, 0);
    check("zext8", 64'(apu_result), 64'h0000_0000_0000_00F0);
    tick();
    vs2_data_i = {$urandom, $urandom, $urandom, $urandom};
    d = vs2_data_i;
    push_one(1, 0, 2, 3, 0);
    check("idx3_32b", 64'(apu_result), 64'(d[127:96]));
    tick();
    push_one(1, 0, 2, 4, 0);
    check("idx4_res", 64'(apu_result), 0);
    check("idx4_flags", 64'(apu_flags_o), 64'b00010);
    tick();
    push_one(1, 0, 3, 0, 1);
    check("vsew3_flags", 64'(apu_flags_o), 64'b00001);
    tick();
    apu_rready_i = 0;
    for (int i = 1; i <= 4; i++) push_one(0, 5'(i), 0, 0, 0);
    check("bp_full", 64'(res_full_o), 1);
    push_one(0, 5, 0, 0, 0);
    check("bp_overflow", 64'(err_overflow_o), 1);
    apu_rready_i = 1;
    for (int i = 1; i <= 4; i++) begin
      check("bp_order", 64'(apu_result), 64'(i));
      tick();
    end
    check("bp_empty", 64'(apu_rvalid), 0);
    apu_rready_i = 0;
    push_one(0, 16, 0, 0, 0);
    do_reset();
    push_one(0, 1, 0, 0, 0);
    push_one(0, 2, 0, 0, 0);
    apu_rready_i = 1;
    for (int i = 3; i < 13; i++) push_one(0, 5'(i), 0, 0, 0);
    tick();
    tick();
    for (int i = 0; i < 400; i++) begin
      apu_rready_i = $urandom_range(0, 3) != 0;
      res_valid_i = $urandom_range(0, 1) == 1;
      res_src_i = 2'($urandom);
      vl_i = 5'($urandom);
      vsew_i = 2'($urandom);
      elem_idx_i = 4'($urandom);
      sext_i = 1'($urandom);
      vs2_data_i = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    res_valid_i = 0;
    apu_rready_i = 1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
`ifdef APU_RESULT_BYPASS_EN
    do_reset();
    apu_rready_i = 1;
    res_valid_i = 1;
    res_src_i = 0;
    vl_i = 8;
    #1;
    check("byp_rvalid", 64'(apu_rvalid), 1);
    check("byp_result", 64'(apu_result), 8);
    res_valid_i = 0;
    tick();
    check("byp_count0", 64'(apu_rvalid), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
